sdram_seq_ctrl: RTL and testbench

//  Sequences SDRAM power-up init (wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE) and then schedules periodic auto-refresh.

---
 rtl/sdram_seq_ctrl_pkg.sv | 29 ++
 rtl/sdram_seq_ctrl_if.sv | 20 ++
 rtl/sdram_seq_ctrl_ref_timer.sv | 42 ++++
 rtl/sdram_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sdram_seq_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sdram_seq_ctrl_pkg.sv
// Shared SDRAM sequencer definitions: command encodings, FSM states, default mode word.
package sdram_pkg;

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_AREF    = 4'b0001;
  localparam logic [3:0] CMD_LMR     = 4'b0000;

  localparam logic [12:0] MODE_REG_DEFAULT = 13'h032;
  localparam int unsigned PRE_ALL_BIT      = 10;

  typedef enum logic [3:0] {
    ST_WAIT_PWR,
    ST_PRE,
    ST_WAIT_RP,
    ST_AREF,
    ST_WAIT_RFC,
    ST_LMR,
    ST_WAIT_MRD,
    ST_IDLE,
    ST_R_PRE,
    ST_R_WAIT_RP,
    ST_R_AREF,
    ST_R_WAIT_RFC,
    ST_USER
  } seq_state_t;

endpackage

// File: rtl/sdram_seq_ctrl_if.sv
// SDRAM command bus plus user-engine request/busy/grant handshake.
interface sdram_seq_ctrl_if;
  logic [3:0]  cmd_o;
  logic [12:0] addr_o;
  logic [1:0]  ba_o;
  logic        cke_o;
  logic        user_req_i;
  logic        user_busy_i;
  logic        user_grant_o;

  modport master (
    output cmd_o, addr_o, ba_o, cke_o, user_grant_o,
    input  user_req_i, user_busy_i
  );

  modport slave (
    input  cmd_o, addr_o, ba_o, cke_o, user_grant_o,
    output user_req_i, user_busy_i
  );
endinterface

// File: rtl/sdram_seq_ctrl_ref_timer.sv
// Free-running refresh period counter with single pending flag and sticky late flag.
module sdram_ref_timer #(
  parameter int unsigned REF_PERIOD = 780
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  input  logic clr,
  output logic pending_o,
  output logic late_o
);

  localparam int unsigned CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = en && (cnt == CNT_W'(REF_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pending_o <= 1'b0;
      late_o    <= 1'b0;
    end else if (restart) begin
      cnt       <= '0;
      pending_o <= 1'b0;
      late_o    <= 1'b0;
    end else begin
      if (en) cnt <= wrap ? '0 : cnt + 1'b1;
      // A wrap coinciding with the FSM taking the request starts a fresh period, not a late one
      if (wrap) begin
        pending_o <= 1'b1;
        if (pending_o && !clr) late_o <= 1'b1;
      end else if (clr) begin
        pending_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_seq_ctrl.sv
// SDRAM init sequencer, periodic refresh scheduler and command-bus arbiter.
// Optional saturating refresh counter on ref_cnt_o when SDRAM_REF_CNT_EN is defined.
module sdram_seq_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned INIT_WAIT  = 20000,
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned T_RP       = 2,
  parameter int unsigned T_RFC      = 7,
  parameter int unsigned T_MRD      = 2,
  parameter int unsigned INIT_REFS  = 8,
  parameter logic [12:0] MODE_REG   = MODE_REG_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sdram_rst_n,
  sdram_seq_ctrl_if.master        bus,
  output logic                    init_done_o,
  output logic                    ref_late_o
`ifdef SDRAM_REF_CNT_EN
  ,
  output logic [15:0]             ref_cnt_o
`endif
);

  localparam int unsigned DLY_W = $clog2(INIT_WAIT + 1);
  localparam int unsigned IDX_W = $clog2(INIT_REFS);

  seq_state_t       state;
  logic [DLY_W-1:0] dly;
  logic [IDX_W-1:0] ref_idx;
  logic [3:0]       cmd_q;
  logic [12:0]      addr_q;
  logic             cke_q;
  logic             grant_q;
  logic             ref_pending;
  logic             ref_take;

  assign ref_take = (state == ST_IDLE) && ref_pending;

  assign bus.cmd_o        = cmd_q;
  assign bus.addr_o       = addr_q;
  assign bus.ba_o         = '0;
  assign bus.cke_o        = cke_q;
  assign bus.user_grant_o = grant_q;

  // dly is set to 1 on each command edge; the next command issues once dly reaches T_x
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT_PWR;
      dly         <= '0;
      ref_idx     <= '0;
      cmd_q       <= CMD_INHIBIT;
      addr_q      <= '0;
      cke_q       <= 1'b0;
      init_done_o <= 1'b0;
      grant_q     <= 1'b0;
    end else if (!sdram_rst_n) begin
      state       <= ST_WAIT_PWR;
      dly         <= '0;
      ref_idx     <= '0;
      cmd_q       <= CMD_INHIBIT;
      addr_q      <= '0;
      cke_q       <= 1'b0;
      init_done_o <= 1'b0;
      grant_q     <= 1'b0;
    end else begin
      cmd_q  <= CMD_NOP;
      addr_q <= '0;
      cke_q  <= 1'b1;
      unique case (state)
        ST_WAIT_PWR: begin
          if (dly == DLY_W'(INIT_WAIT)) begin
            cmd_q               <= CMD_PRE;
            addr_q[PRE_ALL_BIT] <= 1'b1;
            state               <= ST_PRE;
            dly                 <= DLY_W'(1);
            ref_idx             <= '0;
          end else begin
            dly <= dly + 1'b1;
          end
        end
        ST_PRE, ST_WAIT_RP: begin
          if (dly >= DLY_W'(T_RP)) begin
            cmd_q <= CMD_AREF;
            state <= ST_AREF;
            dly   <= DLY_W'(1);
          end else begin
            dly   <= dly + 1'b1;
            state <= ST_WAIT_RP;
          end
        end
        ST_AREF, ST_WAIT_RFC: begin
          if (dly >= DLY_W'(T_RFC)) begin
            dly <= DLY_W'(1);
            if (ref_idx == IDX_W'(INIT_REFS - 1)) begin
              cmd_q  <= CMD_LMR;
              addr_q <= MODE_REG;
              state  <= ST_LMR;
            end else begin
              cmd_q   <= CMD_AREF;
              state   <= ST_AREF;
              ref_idx <= ref_idx + 1'b1;
            end
          end else begin
            dly   <= dly + 1'b1;
            state <= ST_WAIT_RFC;
          end
        end
        ST_LMR, ST_WAIT_MRD: begin
          if (dly >= DLY_W'(T_MRD)) begin
            state       <= ST_IDLE;
            init_done_o <= 1'b1;
          end else begin
            dly   <= dly + 1'b1;
            state <= ST_WAIT_MRD;
          end
        end
        ST_IDLE: begin
          if (ref_pending) begin
            cmd_q               <= CMD_PRE;
            addr_q[PRE_ALL_BIT] <= 1'b1;
            state               <= ST_R_PRE;
            dly                 <= DLY_W'(1);
          end else if (bus.user_req_i) begin
            grant_q <= 1'b1;
            state   <= ST_USER;
          end
        end
        ST_R_PRE, ST_R_WAIT_RP: begin
          if (dly >= DLY_W'(T_RP)) begin
            cmd_q <= CMD_AREF;
            state <= ST_R_AREF;
            dly   <= DLY_W'(1);
          end else begin
            dly   <= dly + 1'b1;
            state <= ST_R_WAIT_RP;
          end
        end
        ST_R_AREF, ST_R_WAIT_RFC: begin
          if (dly >= DLY_W'(T_RFC)) begin
            state <= ST_IDLE;
          end else begin
            dly   <= dly + 1'b1;
            state <= ST_R_WAIT_RFC;
          end
        end
        ST_USER: begin
          if (!bus.user_busy_i) begin
            grant_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_WAIT_PWR;
      endcase
    end
  end

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (!sdram_rst_n),
    .en        (init_done_o),
    .clr       (ref_take),
    .pending_o (ref_pending),
    .late_o    (ref_late_o)
  );

`ifdef SDRAM_REF_CNT_EN
  // Counts the cycle after AREF is on the bus; restart priority drops an in-flight count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_o <= '0;
    end else if (!sdram_rst_n) begin
      ref_cnt_o <= '0;
    end else if (cmd_q == CMD_AREF && ref_cnt_o != '1) begin
      ref_cnt_o <= ref_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_seq_ctrl.sv
// Directed bench for sdram_seq_ctrl with short timing parameters.
module tb_sdram_seq_ctrl;

  localparam logic [3:0]  C_INH  = 4'b1111;
  localparam logic [3:0]  C_NOP  = 4'b0111;
  localparam logic [3:0]  C_PRE  = 4'b0010;
  localparam logic [3:0]  C_AREF = 4'b0001;
  localparam logic [3:0]  C_LMR  = 4'b0000;
  localparam logic [12:0] A_PRE  = 13'h0400;
  localparam logic [12:0] A_MODE = 13'h0032;

  logic clk = 1'b0;
  logic rst_n;
  logic sdram_rst_n;
  logic init_done;
  logic ref_late;
`ifdef SDRAM_REF_CNT_EN
  logic [15:0] ref_cnt;
`endif

  int checks = 0;
  int errors = 0;

  sdram_seq_ctrl_if bus ();

  sdram_seq_ctrl #(
    .INIT_WAIT  (20),
    .REF_PERIOD (40),
    .T_RP       (2),
    .T_RFC      (7),
    .T_MRD      (2),
    .INIT_REFS  (2),
    .MODE_REG   (13'h032)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sdram_rst_n (sdram_rst_n),
    .bus         (bus),
    .init_done_o (init_done),
    .ref_late_o  (ref_late)
`ifdef SDRAM_REF_CNT_EN
    ,
    .ref_cnt_o   (ref_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sdram_rst_n = 1'b1;
    bus.user_req_i = 1'b0;
    bus.user_busy_i = 1'b0;
    repeat (3) tick();
    checks++; if (bus.cmd_o !== C_INH) begin errors++; $display("FAIL reset_cmd got %b want %b", bus.cmd_o, C_INH); end
    checks++; if (bus.addr_o !== 13'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.addr_o); end
    checks++; if (bus.ba_o !== 2'b00) begin errors++; $display("FAIL reset_ba got %b want 00", bus.ba_o); end
    checks++; if (bus.cke_o !== 1'b0) begin errors++; $display("FAIL reset_cke got %b want 0", bus.cke_o); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
    checks++; if (bus.user_grant_o !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", bus.user_grant_o); end
    checks++; if (ref_late !== 1'b0) begin errors++; $display("FAIL reset_late got %b want 0", ref_late); end
  endtask

  // Partial init, then sdram_rst_n held low 100 cycles with a user request present
  task automatic test_restart();
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      checks++; if (bus.cke_o !== 1'b1) begin errors++; $display("FAIL pre_restart_cke c=%0d got %b want 1", c, bus.cke_o); end
    end
`ifdef SDRAM_REF_CNT_EN
    checks++; if (ref_cnt !== 16'd1) begin errors++; $display("FAIL mid_init_ref_cnt got %0d want 1", ref_cnt); end
`endif
    sdram_rst_n = 1'b0;
    bus.user_req_i = 1'b1;
    bus.user_busy_i = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++; if (bus.cmd_o !== C_INH) begin errors++; $display("FAIL restart_cmd c=%0d got %b want %b", c, bus.cmd_o, C_INH); end
      checks++; if (bus.cke_o !== 1'b0) begin errors++; $display("FAIL restart_cke c=%0d got %b want 0", c, bus.cke_o); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL restart_init_done c=%0d got %b want 0", c, init_done); end
      checks++; if (bus.user_grant_o !== 1'b0) begin errors++; $display("FAIL restart_grant c=%0d got %b want 0", c, bus.user_grant_o); end
      checks++; if (bus.addr_o !== 13'h0) begin errors++; $display("FAIL restart_addr c=%0d got %h want 0", c, bus.addr_o); end
    end
`ifdef SDRAM_REF_CNT_EN
    checks++; if (ref_cnt !== 16'd0) begin errors++; $display("FAIL restart_ref_cnt got %0d want 0", ref_cnt); end
`endif
    bus.user_busy_i = 1'b0;
  endtask

  // Cycle 0 is the first edge with sdram_rst_n high; user_req stays high until cycle 37
  task automatic test_init();
    logic [3:0]  exp_cmd;
    logic [12:0] exp_addr;
    sdram_rst_n = 1'b1;
    for (int c = 0; c <= 38; c++) begin
      tick();
      exp_cmd  = C_NOP;
      exp_addr = 13'h0;
      if (c == 20) begin exp_cmd = C_PRE; exp_addr = A_PRE; end
      if (c == 22 || c == 29) exp_cmd = C_AREF;
      if (c == 36) begin exp_cmd = C_LMR; exp_addr = A_MODE; end
      checks++; if (bus.cmd_o !== exp_cmd) begin errors++; $display("FAIL init_cmd c=%0d got %b want %b", c, bus.cmd_o, exp_cmd); end
      checks++; if (bus.addr_o !== exp_addr) begin errors++; $display("FAIL init_addr c=%0d got %h want %h", c, bus.addr_o, exp_addr); end
      checks++; if (bus.cke_o !== 1'b1) begin errors++; $display("FAIL init_cke c=%0d got %b want 1", c, bus.cke_o); end
      checks++; if (init_done !== (c >= 38)) begin errors++; $display("FAIL init_done c=%0d got %b want %b", c, init_done, c >= 38); end
      checks++; if (bus.user_grant_o !== 1'b0) begin errors++; $display("FAIL init_grant c=%0d got %b want 0", c, bus.user_grant_o); end
      if (c == 37) bus.user_req_i = 1'b0;
    end
`ifdef SDRAM_REF_CNT_EN
    checks++; if (ref_cnt !== 16'd2) begin errors++; $display("FAIL init_ref_cnt got %0d want 2", ref_cnt); end
`endif
  endtask

  // Timer starts at cycle 38: pending visible at 78, 118, 158 -> PRE one cycle later
  task automatic test_refresh();
    logic [3:0] exp_cmd;
    for (int c = 39; c <= 170; c++) begin
      tick();
      exp_cmd = C_NOP;
      if (c >= 79 && (c - 79) % 40 == 0) exp_cmd = C_PRE;
      if (c >= 81 && (c - 81) % 40 == 0) exp_cmd = C_AREF;
      checks++; if (bus.cmd_o !== exp_cmd) begin errors++; $display("FAIL refresh_cmd c=%0d got %b want %b", c, bus.cmd_o, exp_cmd); end
      checks++; if (bus.addr_o !== ((exp_cmd == C_PRE) ? A_PRE : 13'h0)) begin errors++; $display("FAIL refresh_addr c=%0d got %h", c, bus.addr_o); end
      checks++; if (bus.user_grant_o !== 1'b0) begin errors++; $display("FAIL refresh_grant c=%0d got %b want 0", c, bus.user_grant_o); end
      checks++; if (ref_late !== 1'b0) begin errors++; $display("FAIL refresh_late c=%0d got %b want 0", c, ref_late); end
    end
`ifdef SDRAM_REF_CNT_EN
    checks++; if (ref_cnt !== 16'd5) begin errors++; $display("FAIL refresh_ref_cnt got %0d want 5", ref_cnt); end
`endif
  endtask

  // Request arrives with pending at 198; long grant makes refresh late at 278
  task automatic test_tie_grant();
    logic [3:0] exp_cmd;
    logic       exp_grant;
    for (int c = 171; c <= 303; c++) begin
      tick();
      exp_cmd = C_NOP;
      if (c == 199 || c == 301) exp_cmd = C_PRE;
      if (c == 201 || c == 303) exp_cmd = C_AREF;
      exp_grant = (c >= 209 && c <= 299);
      checks++; if (bus.cmd_o !== exp_cmd) begin errors++; $display("FAIL tie_cmd c=%0d got %b want %b", c, bus.cmd_o, exp_cmd); end
      checks++; if (bus.user_grant_o !== exp_grant) begin errors++; $display("FAIL tie_grant c=%0d got %b want %b", c, bus.user_grant_o, exp_grant); end
      checks++; if (ref_late !== (c >= 278)) begin errors++; $display("FAIL tie_late c=%0d got %b want %b", c, ref_late, c >= 278); end
      if (c == 198) begin bus.user_req_i = 1'b1; bus.user_busy_i = 1'b1; end
      if (c == 299) begin bus.user_req_i = 1'b0; bus.user_busy_i = 1'b0; end
    end
  endtask

  // Plain request with no refresh pending: grant the next cycle, two-cycle hold
  task automatic test_back_to_back();
    logic [3:0] exp_cmd;
    for (int c = 304; c <= 320; c++) begin
      tick();
      exp_cmd = (c == 319) ? C_PRE : C_NOP;
      checks++; if (bus.cmd_o !== exp_cmd) begin errors++; $display("FAIL b2b_cmd c=%0d got %b want %b", c, bus.cmd_o, exp_cmd); end
      checks++; if (bus.user_grant_o !== (c == 311 || c == 312)) begin errors++; $display("FAIL b2b_grant c=%0d got %b", c, bus.user_grant_o); end
      checks++; if (ref_late !== 1'b1) begin errors++; $display("FAIL b2b_late c=%0d got %b want 1", c, ref_late); end
      if (c == 310) begin bus.user_req_i = 1'b1; bus.user_busy_i = 1'b1; end
      if (c == 312) begin bus.user_req_i = 1'b0; bus.user_busy_i = 1'b0; end
    end
`ifdef SDRAM_REF_CNT_EN
    checks++; if (ref_cnt !== 16'd7) begin errors++; $display("FAIL b2b_ref_cnt got %0d want 7", ref_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_restart();
    bus.user_req_i = 1'b1;
    test_init();
    test_refresh();
    test_tie_grant();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
